note_display_ctrl: RTL and testbench
====================================

NOTE_DISPLAY_CTRL -- requirements
Module: note_display_ctrl

Interface
REQ-001 Parameters SHALL be: DRAW_CYCLES, default 448, fixed drawer busy time per note; SLOT_W, default 40, horizontal pixel pitch; ROW_H, default 14, vertical pixel pitch; SLOTS, default 4, slots per row; ROWS, default 8, rows per screen.
REQ-002 One clock (clk); reset is asynchronous and active-low (resetn).
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- note_in  in  4  detected note code, 1..12 = A..G#
- octave_in  in  2  detected octave
- note_valid  in  1  one-cycle strobe, note_in/octave_in valid
- clear_screen  in  1  one-cycle strobe, restart slot position at origin
- note  out  4  note code to drawer
- octave  out  2  octave to drawer
- x  out  8  glyph origin x to drawer
- y  out  7  glyph origin y to drawer
- ld_note  out  1  one-cycle draw-start pulse to drawer
- colour_in  out  3  glyph colour to drawer
- busy  out  1  drawer occupied
- dropped  out  1  one-cycle pulse, pending note overwritten

Function
REQ-004 FSM states SHALL be IDLE, LOAD and WAIT, with registered outputs only.
REQ-005 IDLE, accepted note_valid at edge N: note, octave and colour_in SHALL update at N+1, with LOAD entered at N+1.
REQ-006 A note_valid SHALL be accepted only if note_in is 1..12; codes 0 and 13..15 SHALL be ignored with no state change.
REQ-007 LOAD SHALL last exactly one cycle with ld_note=1, then enter WAIT.
REQ-008 WAIT SHALL last exactly DRAW_CYCLES cycles, counted by an internal counter cleared on entering WAIT.
REQ-009 busy SHALL be 1 in LOAD and WAIT and 0 in IDLE.
REQ-010 note, octave, x, y and colour_in SHALL be held stable from LOAD through the last WAIT cycle.
REQ-011 colour_in SHALL be 3'b100 for octave 0, 3'b010 for octave 1, 3'b001 for octave 2 and 3'b111 for octave 3.
REQ-012 x SHALL equal slot*SLOT_W and y SHALL equal row*ROW_H, with slot and row as internal counters.
REQ-013 On leaving WAIT, slot SHALL increment; at SLOTS-1 it SHALL wrap to 0 and row SHALL increment; row SHALL wrap from ROWS-1 to 0.
REQ-014 The new slot/row value SHALL appear on x/y in the cycle after WAIT ends.
REQ-015 A valid note arriving while busy SHALL be stored in a one-entry pending buffer.
REQ-016 If the pending buffer is already full, the newest note SHALL overwrite it and dropped SHALL pulse for one cycle.
REQ-017 At WAIT end with pending full, the FSM SHALL go directly to LOAD with the pending note and mark the buffer empty; otherwise it SHALL go to IDLE.
REQ-018 A valid note coinciding with the final WAIT cycle SHALL be treated as arriving while busy.
REQ-019 clear_screen in IDLE SHALL zero slot and row at the next edge.
REQ-020 clear_screen while busy SHALL be latched and applied at WAIT end, before slot advance; the next glyph SHALL go to (0,0).
REQ-021 If clear_screen and note_valid coincide in IDLE, the clear SHALL apply first and the note SHALL be drawn at (0,0).

Reset
REQ-022 While resetn=0, the block SHALL be in IDLE with note=0, octave=0, x=0, y=0, ld_note=0, colour_in=0, busy=0 and dropped=0.
REQ-023 While resetn=0, slot, row, the WAIT counter, the pending buffer and the clear latch SHALL be 0.
REQ-024 Reset asserted mid-LOAD or mid-WAIT SHALL abort immediately to the REQ-022/REQ-023 values.
REQ-025 The first note after reset release SHALL be drawn at (0,0).

Verification
REQ-026 Reset, then note_in=4'd5, octave_in=2'd1, note_valid at edge 10 -> cycle 11: ld_note=1, note=5, colour_in=3'b010, x=0, y=0; busy high through cycle 11+DRAW_CYCLES; x=40 in the following cycle.
REQ-027 Five notes back-to-back, each sent after busy falls -> origins (0,0), (40,0), (80,0), (120,0), (0,14).
REQ-028 During WAIT, send note 3 then note 7 -> dropped pulses once; after WAIT the next LOAD carries note=7; note 3 is never drawn.
REQ-029 note_in=0 and note_in=13 with note_valid in IDLE -> no ld_note, busy stays 0, slot unchanged.
REQ-030 clear_screen mid-WAIT at slot (80,28) -> next glyph at (0,0); reset asserted mid-WAIT -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/note_display_ctrl.sv
// Note display controller: queues detected notes and hands them to a glyph
// drawer, stepping the glyph origin across a fixed grid of slots and rows.
module note_display_ctrl #(
    parameter int unsigned DRAW_CYCLES = 448,
    parameter int unsigned SLOT_W      = 40,
    parameter int unsigned ROW_H       = 14,
    parameter int unsigned SLOTS       = 4,
    parameter int unsigned ROWS        = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    input  logic       note_valid,
    input  logic       clear_screen,
    output logic [3:0] note,
    output logic [1:0] octave,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       ld_note,
    output logic [2:0] colour_in,
    output logic       busy,
    output logic       dropped
);

    localparam int unsigned CW = $clog2(DRAW_CYCLES + 1);
    localparam int unsigned SB = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned RB = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SB-1:0] slot_q, slot_d;
    logic [RB-1:0] row_q, row_d;
    logic          pend_q, pend_d;
    logic [3:0]    pnote_q, pnote_d;
    logic [1:0]    poct_q, poct_d;
    logic          clr_q, clr_d;
    logic [3:0]    note_d;
    logic [1:0]    oct_d;
    logic [2:0]    col_d;
    logic          ld_d;
    logic          drop_d;
    logic          accept;
    logic          last;

    function automatic logic [2:0] colour_of(input logic [1:0] o);
        case (o)
            2'd0:    colour_of = 3'b100;
            2'd1:    colour_of = 3'b010;
            2'd2:    colour_of = 3'b001;
            default: colour_of = 3'b111;
        endcase
    endfunction

    always_comb begin
        accept  = note_valid && (note_in != 4'd0) && (note_in <= 4'd12);
        last    = (state_q == WAIT) && (cnt_q == CW'(DRAW_CYCLES - 1));
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        row_d   = row_q;
        pend_d  = pend_q;
        pnote_d = pnote_q;
        poct_d  = poct_q;
        clr_d   = clr_q;
        note_d  = note;
        oct_d   = octave;
        col_d   = colour_in;
        ld_d    = 1'b0;
        drop_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (clear_screen) begin
                    slot_d = '0;
                    row_d  = '0;
                end
                if (accept) begin
                    state_d = LOAD;
                    note_d  = note_in;
                    oct_d   = octave_in;
                    col_d   = colour_of(octave_in);
                    ld_d    = 1'b1;
                end
            end
            LOAD: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT:    cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase

        // While the drawer is occupied, notes and clears are deferred
        if (state_q != IDLE) begin
            if (accept) begin
                drop_d  = pend_q;
                pend_d  = 1'b1;
                pnote_d = note_in;
                poct_d  = octave_in;
            end
            if (clear_screen) clr_d = 1'b1;
        end

        if (last) begin
            cnt_d = '0;
            if (clr_d) begin
                slot_d = '0;
                row_d  = '0;
            end else if (slot_q == SB'(SLOTS - 1)) begin
                slot_d = '0;
                row_d  = (row_q == RB'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end
            clr_d = 1'b0;
            if (pend_d) begin
                state_d = LOAD;
                note_d  = pnote_d;
                oct_d   = poct_d;
                col_d   = colour_of(poct_d);
                ld_d    = 1'b1;
                pend_d  = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            row_q     <= '0;
            pend_q    <= 1'b0;
            pnote_q   <= '0;
            poct_q    <= '0;
            clr_q     <= 1'b0;
            note      <= '0;
            octave    <= '0;
            colour_in <= '0;
            x         <= '0;
            y         <= '0;
            ld_note   <= 1'b0;
            busy      <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            row_q     <= row_d;
            pend_q    <= pend_d;
            pnote_q   <= pnote_d;
            poct_q    <= poct_d;
            clr_q     <= clr_d;
            note      <= note_d;
            octave    <= oct_d;
            colour_in <= col_d;
            x         <= 8'(slot_d * SLOT_W);
            y         <= 7'(row_d * ROW_H);
            ld_note   <= ld_d;
            busy      <= (state_d != IDLE);
            dropped   <= drop_d;
        end
    end

endmodule

// File: tb/tb_note_display_ctrl.sv
// Bench for note_display_ctrl: directed scenarios plus a randomized run
// against a transaction-level model of the drawer queue and glyph grid.
module tb_note_display_ctrl;

    localparam int D  = 448;
    localparam int SW = 40;
    localparam int RH = 14;
    localparam int NS = 4;
    localparam int NR = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] note_in = '0;
    logic [1:0] octave_in = '0;
    logic       note_valid = 1'b0;
    logic       clear_screen = 1'b0;
    logic [3:0] note;
    logic [1:0] octave;
    logic [7:0] x;
    logic [6:0] y;
    logic       ld_note;
    logic [2:0] colour_in;
    logic       busy;
    logic       dropped;

    int total = 0;
    int bad = 0;

    note_display_ctrl dut (
        .clk(clk), .resetn(resetn), .note_in(note_in),
        .octave_in(octave_in), .note_valid(note_valid),
        .clear_screen(clear_screen), .note(note), .octave(octave),
        .x(x), .y(y), .ld_note(ld_note), .colour_in(colour_in),
        .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Model: rem = busy cycles left, pos = linear glyph index on screen
    int         rem;
    int         pos;
    bit         pv;
    bit         cl;
    logic [3:0] pn;
    logic [1:0] po;
    logic [3:0] e_note;
    logic [1:0] e_oct;
    logic [2:0] e_col;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic       e_ld, e_busy, e_drop;
    logic [2:0] col_tab [4] = '{3'b100, 3'b010, 3'b001, 3'b111};

    function automatic void model_reset();
        rem = 0; pos = 0; pv = 0; cl = 0; pn = 0; po = 0;
        e_note = 0; e_oct = 0; e_col = 0; e_x = 0; e_y = 0;
        e_ld = 0; e_busy = 0; e_drop = 0;
    endfunction

    function automatic void start_draw(logic [3:0] n, logic [1:0] o);
        rem = D + 1;
        e_note = n;
        e_oct = o;
        e_col = col_tab[o];
        e_ld = 1;
    endfunction

    function automatic void model_step(logic v, logic [3:0] n,
                                       logic [1:0] o, logic c);
        bit acc;
        acc = v && n >= 1 && n <= 12;
        e_ld = 0;
        e_drop = 0;
        if (rem > 0) begin
            if (acc) begin
                if (pv) e_drop = 1;
                pv = 1; pn = n; po = o;
            end
            if (c) cl = 1;
            rem--;
            if (rem == 0) begin
                pos = cl ? 0 : (pos + 1) % (NS * NR);
                cl = 0;
                if (pv) begin
                    pv = 0;
                    start_draw(pn, po);
                end
            end
        end else begin
            if (c) pos = 0;
            if (acc) start_draw(n, o);
        end
        e_busy = rem > 0;
        e_x = 8'((pos % NS) * SW);
        e_y = 7'((pos / NS) * RH);
    endfunction

    function automatic logic [26:0] exp_vec();
        return {e_ld, e_busy, e_drop, e_note, e_oct, e_col, e_x, e_y};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {ld_note, busy, dropped, note, octave, colour_in, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(note_valid, note_in, octave_in, clear_screen);
        #1;
        note_valid = 0;
        clear_screen = 0;
    endtask

    task automatic send(input logic [3:0] n, input logic [1:0] o);
        note_in = n;
        octave_in = o;
        note_valid = 1;
        tick();
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < D + 20; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        note_valid = 0;
        clear_screen = 0;
        resetn = 0;
        #2;
        resetn = 1;
        model_reset();
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_vec() !== 27'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=0", dut_vec());
        end
        resetn = 1;
        model_reset();
        tick();
        total++;
        if (dut_vec() !== 27'd0) begin
            bad++;
            $display("FAIL reset_release got=%h exp=0", dut_vec());
        end
    endtask

    task automatic test_first_note();
        int n;
        int hold_err;
        repeat (8) tick();
        send(4'd5, 2'd1);
        total++;
        if (!(ld_note === 1 && note === 5 && octave === 1 &&
              colour_in === 3'b010 && x === 0 && y === 0 && busy === 1)) begin
            bad++;
            $display("FAIL first_load got=%h exp ld=1 note=5 col=2 xy=0",
                     dut_vec());
        end
        n = 1;
        hold_err = 0;
        for (int i = 0; i < D + 20; i++) begin
            tick();
            if (!busy) break;
            n++;
            if (ld_note !== 0 || note !== 5 || colour_in !== 3'b010 ||
                x !== 0 || y !== 0)
                hold_err++;
        end
        total++;
        if (hold_err != 0) begin
            bad++;
            $display("FAIL first_hold got=%0d unstable cycles exp=0", hold_err);
        end
        total++;
        if (n != D + 1) begin
            bad++;
            $display("FAIL first_busy_len got=%0d exp=%0d", n, D + 1);
        end
        total++;
        if (x !== 8'd40 || y !== 7'd0 || busy !== 0) begin
            bad++;
            $display("FAIL first_advance got x=%0d y=%0d busy=%0d exp 40 0 0",
                     x, y, busy);
        end
    endtask

    task automatic test_back_to_back();
        int ex [5] = '{0, 40, 80, 120, 0};
        int ey [5] = '{0, 0, 0, 0, 14};
        bit ok;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            wait_idle(ok);
            send(4'(k + 1), 2'(k));
            total++;
            if (!ok || ld_note !== 1 || x !== 8'(ex[k]) || y !== 7'(ey[k])) begin
                bad++;
                $display("FAIL b2b_%0d got ok=%0d ld=%0d x=%0d y=%0d exp %0d,%0d",
                         k, ok, ld_note, x, y, ex[k], ey[k]);
            end
        end
    endtask

    task automatic test_drop();
        int drops;
        int loads;
        int saw3;
        logic [3:0] ln;
        logic [7:0] lx;
        apply_reset();
        send(4'd1, 2'd0);
        repeat (20) tick();
        send(4'd3, 2'd2);
        drops = int'(dropped);
        repeat (10) begin
            tick();
            drops += int'(dropped);
        end
        send(4'd7, 2'd3);
        drops += int'(dropped);
        loads = 0; saw3 = 0; ln = 0; lx = 0;
        for (int i = 0; i < 2 * D + 40; i++) begin
            tick();
            drops += int'(dropped);
            if (ld_note) begin
                loads++;
                if (loads == 1) begin
                    ln = note;
                    lx = x;
                end
                if (note == 3) saw3++;
            end
        end
        total++;
        if (drops != 1) begin
            bad++;
            $display("FAIL drop_pulses got=%0d exp=1", drops);
        end
        total++;
        if (loads != 1 || ln !== 4'd7 || lx !== 8'd40) begin
            bad++;
            $display("FAIL drop_next got loads=%0d note=%0d x=%0d exp 1 7 40",
                     loads, ln, lx);
        end
        total++;
        if (saw3 != 0) begin
            bad++;
            $display("FAIL drop_no3 got=%0d exp=0", saw3);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] x0;
        bit ok;
        wait_idle(ok);
        x0 = x;
        send(4'd0, 2'd2);
        total++;
        if (!ok || ld_note !== 0 || busy !== 0) begin
            bad++;
            $display("FAIL invalid_0 got ld=%0d busy=%0d exp 0 0", ld_note, busy);
        end
        send(4'd13, 2'd1);
        total++;
        if (ld_note !== 0 || busy !== 0) begin
            bad++;
            $display("FAIL invalid_13 got ld=%0d busy=%0d exp 0 0", ld_note, busy);
        end
        send(4'd12, 2'd0);
        total++;
        if (ld_note !== 1 || x !== x0 || note !== 4'd12) begin
            bad++;
            $display("FAIL invalid_slot got ld=%0d x=%0d note=%0d exp 1 %0d 12",
                     ld_note, x, note, x0);
        end
    endtask

    task automatic test_clear();
        bit ok;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            wait_idle(ok);
            send(4'd2, 2'd1);
        end
        wait_idle(ok);
        send(4'd4, 2'd2);
        total++;
        if (!ok || x !== 8'd80 || y !== 7'd28) begin
            bad++;
            $display("FAIL clear_pos got x=%0d y=%0d exp 80 28", x, y);
        end
        repeat (100) tick();
        clear_screen = 1;
        tick();
        wait_idle(ok);
        send(4'd6, 2'd0);
        total++;
        if (!ok || ld_note !== 1 || x !== 0 || y !== 0) begin
            bad++;
            $display("FAIL clear_origin got ld=%0d x=%0d y=%0d exp 1 0 0",
                     ld_note, x, y);
        end
        repeat (50) tick();
        resetn = 0;
        #1;
        total++;
        if (dut_vec() !== 27'd0) begin
            bad++;
            $display("FAIL reset_mid_wait got=%h exp=0", dut_vec());
        end
        #1;
        resetn = 1;
        model_reset();
        send(4'd9, 2'd3);
        total++;
        if (ld_note !== 1 || x !== 0 || y !== 0 || colour_in !== 3'b111) begin
            bad++;
            $display("FAIL reset_first got ld=%0d x=%0d y=%0d col=%0d exp 1 0 0 7",
                     ld_note, x, y, colour_in);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 12000; i++) begin
            note_in = 4'($urandom_range(0, 15));
            octave_in = 2'($urandom_range(0, 3));
            note_valid = ($urandom_range(0, 149) == 0);
            clear_screen = ($urandom_range(0, 599) == 0);
            tick();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                if (bad < 20)
                    $display("FAIL rand_cyc%0d got=%h exp=%h",
                             i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_note();
        test_back_to_back();
        test_drop();
        test_invalid();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
